// File: rtl/mvm_arbiter.sv
// mvm_arbiter: shares one mat_vec_mul between two requesters, round-robin
// issue, tag pipeline routes each result back to its originator in order.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   req_valid/req_ready       per-requester issue handshake
//   req_A, req_x              per-requester 4x4 matrix and 4-vector
//   res_valid/res_ready       per-requester result handshake
//   res_y                     shared result vector, qualified by res_valid
//   mvm_enable                pipeline enable to the multiplier
//   mvm_A, mvm_x, mvm_dv      issue port to the multiplier
//   mvm_y, mvm_o_dv           result port from the multiplier
//   inflight                  issued operations not yet retired
module mvm_arbiter #(
    parameter int DATAWIDTH = 18,
    parameter int LATENCY   = 5
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic signed [DATAWIDTH-1:0] req_A [2][4][4],
    input  logic signed [DATAWIDTH-1:0] req_x [2][4],
    output logic [1:0]                  res_valid,
    input  logic [1:0]                  res_ready,
    output logic signed [DATAWIDTH-1:0] res_y [4],
    output logic                        mvm_enable,
    output logic signed [DATAWIDTH-1:0] mvm_A [4][4],
    output logic signed [DATAWIDTH-1:0] mvm_x [4],
    output logic                        mvm_dv,
    input  logic signed [DATAWIDTH-1:0] mvm_y [4],
    input  logic                        mvm_o_dv,
    output logic [2:0]                  inflight
);

    logic [LATENCY-1:0] tag_v;
    logic [LATENCY-1:0] tag_id;
    logic               tag_out_v;
    logic               tag_out_id;
    logic               rr;
    logic               gnt_any;
    logic               gnt_id;
    logic               retire;

    assign tag_out_v  = tag_v[LATENCY-1];
    assign tag_out_id = tag_id[LATENCY-1];

    // A finished result whose owner is not ready freezes the whole pipe.
    assign mvm_enable = ~(mvm_o_dv & ~res_ready[tag_out_id]);
    assign retire     = mvm_o_dv & mvm_enable;

    // Grants are held off during reset so nothing handshakes then.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (rstn && mvm_enable) begin
            unique case (req_valid)
                2'b11: begin
                    gnt_any = 1'b1;
                    gnt_id  = rr;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end
                2'b01: gnt_any = 1'b1;
                default: ;
            endcase
        end
    end

    assign mvm_dv    = gnt_any;
    assign req_ready = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

    // With no grant gnt_id stays 0, so requester 0 is presented.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mvm_x[i] = req_x[gnt_id][i];
            for (int j = 0; j < 4; j++) begin
                mvm_A[i][j] = req_A[gnt_id][i][j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            res_y[i] = mvm_y[i];
        end
    end

    assign res_valid = mvm_o_dv ? (tag_out_id ? 2'b10 : 2'b01) : 2'b00;

    // Tag pipe mirrors the multiplier: it moves only when the multiplier does.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else if (mvm_enable) begin
            tag_v[0]  <= mvm_dv;
            tag_id[0] <= gnt_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr <= 1'b0;
        end else if (gnt_any) begin
            rr <= ~gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= 3'd0;
        end else if (mvm_dv && !retire) begin
            inflight <= inflight + 3'd1;
        end else if (!mvm_dv && retire) begin
            inflight <= inflight - 3'd1;
        end
    end

`ifndef SYNTHESIS
    a_tag_match: assert property (@(posedge clk) disable iff (!rstn)
        mvm_o_dv |-> tag_out_v);
    a_depth: assert property (@(posedge clk) disable iff (!rstn)
        inflight <= 3'(LATENCY));
`endif

endmodule
